pipe_out_serializer: RTL and testbench

Downstream neighbour of the indication side of the top-level wrapper. Consumes 144-bit indication messages (16-bit tag + 128-bit payload) from a `PipeIn`-style enqueue port and emits them as 32-bit beats on a valid/ready stream toward the host transport. Each message becomes one framing header beat followed by the payload beats. A two-entry buffer lets the next message be accepted while the current one is still being serialized.

---
 rtl/pipe_ser_pkg.sv | 28 ++
 rtl/pipe_ser_fifo2.sv | 74 +++++++
 rtl/pipe_out_serializer.sv | 172 +++++++++++++++++
 tb/tb_pipe_out_serializer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ser_pkg.sv
// rtl/pipe_ser_pkg.sv - shared widths, framing constants and types for pipe_out_serializer
//
// Contents:
//   TAG_WIDTH, DATA_WIDTH, BEAT_WIDTH : default message/beat geometry
//   HDR_MAGIC                         : top byte of every framing header beat
//   msg_t                             : one indication message {tag, data}
//   ser_state_t                       : serializer FSM states (TRL only with PIPE_SER_CHECKSUM_EN)
package pipe_ser_pkg;

  localparam int TAG_WIDTH  = 16;
  localparam int DATA_WIDTH = 128;
  localparam int BEAT_WIDTH = 32;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } msg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    TRL  = 2'd3
  } ser_state_t;

endpackage

// File: rtl/pipe_ser_fifo2.sv
// rtl/pipe_ser_fifo2.sv - two-entry message buffer (head plus one pending) for pipe_out_serializer
//
// Ports:
//   i_clk        : clock, rising edge
//   i_rst_n      : synchronous active-low reset, empties the buffer
//   i_push       : enqueue request; taken only while o_not_full is high
//   i_push_data  : message to enqueue
//   i_pop        : drop the head entry (ignored when empty)
//   o_head       : head entry contents
//   o_empty      : no entries held
//   o_full       : both entries held
//   o_not_full   : registered space-available flag, low during reset
module pipe_ser_fifo2
  import pipe_ser_pkg::*;
#(
  parameter int WIDTH = $bits(msg_t)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_not_full
);

  logic [WIDTH-1:0] r_mem [0:1];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_not_full;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;

  // The registered ready flag gates the push, so a strobe while it is low
  // leaves the buffer untouched.
  assign w_push      = i_push && r_not_full;
  assign w_pop       = i_pop && (r_count != 2'd0);
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

  assign o_head     = r_mem[r_rd_ptr];
  assign o_empty    = (r_count == 2'd0);
  assign o_full     = (r_count == 2'd2);
  assign o_not_full = r_not_full;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_not_full <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count    <= w_count_nxt;
      r_not_full <= (w_count_nxt != 2'd2);
    end
  end

endmodule

// File: rtl/pipe_out_serializer.sv
// rtl/pipe_out_serializer.sv - serializes tagged indication messages into framed 32-bit stream beats
//
// Frame: header {HDR_MAGIC, NBEATS, tag}, then payload words least-significant first.
// Optional feature macro PIPE_SER_CHECKSUM_EN appends an XOR trailer beat.
//
// Ports:
//   CLK          : clock, rising edge
//   nRST         : synchronous active-low reset; abandons any partial frame
//   in_enq__ENA  : enqueue strobe, transfers when in_enq__RDY is high
//   in_enq_v     : message, tag in MSBs, payload in LSBs
//   in_enq__RDY  : buffer has room
//   out_valid    : out_data holds a beat
//   out_data     : current beat
//   out_last     : current beat ends the frame
//   out_ready    : sink takes the beat on this edge
module pipe_out_serializer #(
  parameter int TAG_WIDTH  = pipe_ser_pkg::TAG_WIDTH,
  parameter int DATA_WIDTH = pipe_ser_pkg::DATA_WIDTH,
  parameter int BEAT_WIDTH = pipe_ser_pkg::BEAT_WIDTH
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic                            in_enq__ENA,
  input  logic [TAG_WIDTH+DATA_WIDTH-1:0] in_enq_v,
  output logic                            in_enq__RDY,
  output logic                            out_valid,
  output logic [BEAT_WIDTH-1:0]           out_data,
  output logic                            out_last,
  input  logic                            out_ready
);

  import pipe_ser_pkg::*;

  localparam int N_DATA = DATA_WIDTH / BEAT_WIDTH;
`ifdef PIPE_SER_CHECKSUM_EN
  localparam int NBEATS = N_DATA + 1;
`else
  localparam int NBEATS = N_DATA;
`endif
  localparam int MSG_W = TAG_WIDTH + DATA_WIDTH;
  localparam int CNT_W = (N_DATA > 1) ? $clog2(N_DATA) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DATA - 1);

  logic [MSG_W-1:0]                   w_head;
  logic                               w_empty;
  logic                               w_full;
  logic                               w_not_full;

  ser_state_t                         r_state;
  ser_state_t                         w_state_nxt;
  logic [CNT_W-1:0]                   r_cnt;

  logic                               w_hs;
  logic                               w_last;
  logic                               w_pop;
  logic [TAG_WIDTH-1:0]               w_tag;
  logic [N_DATA-1:0][BEAT_WIDTH-1:0]  w_words;
  logic [BEAT_WIDTH-1:0]              w_hdr;
  logic [BEAT_WIDTH-1:0]              w_beat;
`ifdef PIPE_SER_CHECKSUM_EN
  logic [BEAT_WIDTH-1:0]              r_csum;
`endif

  pipe_ser_fifo2 #(
    .WIDTH (MSG_W)
  ) u_fifo (
    .i_clk       (CLK),
    .i_rst_n     (nRST),
    .i_push      (in_enq__ENA),
    .i_push_data (in_enq_v),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_not_full  (w_not_full)
  );

  assign in_enq__RDY = w_not_full;

  assign w_tag   = w_head[MSG_W-1 -: TAG_WIDTH];
  assign w_words = w_head[DATA_WIDTH-1:0];
  assign w_hdr   = BEAT_WIDTH'({HDR_MAGIC, 8'(NBEATS), w_tag});

  assign out_valid = (r_state != IDLE);
  assign w_hs      = out_valid && out_ready;

`ifdef PIPE_SER_CHECKSUM_EN
  assign w_last = (r_state == TRL);
`else
  assign w_last = (r_state == DATA) && (r_cnt == LAST_CNT);
`endif

  // The head leaves the buffer on the same edge its final beat is taken.
  assign w_pop = w_hs && w_last;

  // A full buffer at the end of a frame means the next message is already
  // waiting, so go straight to its header without an idle bubble.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nxt = HDR;
        end
      end
      HDR: begin
        if (w_hs) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_hs && (r_cnt == LAST_CNT)) begin
`ifdef PIPE_SER_CHECKSUM_EN
          w_state_nxt = TRL;
`else
          w_state_nxt = w_full ? HDR : IDLE;
`endif
        end
      end
      TRL: begin
        if (w_hs) begin
          w_state_nxt = w_full ? HDR : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Counter restarts on any handshake that is not a mid-payload beat,
      // so it is always zero on entry to DATA.
      if (w_hs) begin
        r_cnt <= ((r_state == DATA) && (r_cnt != LAST_CNT)) ? r_cnt + CNT_W'(1) : '0;
      end
    end
  end

`ifdef PIPE_SER_CHECKSUM_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_csum <= '0;
    end else if (w_hs) begin
      if (r_state == HDR) begin
        r_csum <= w_hdr;
      end else if (r_state == DATA) begin
        r_csum <= r_csum ^ w_beat;
      end
    end
  end
`endif

  always_comb begin
    w_beat = '0;
    case (r_state)
      HDR:  w_beat = w_hdr;
      DATA: w_beat = w_words[r_cnt];
`ifdef PIPE_SER_CHECKSUM_EN
      TRL:  w_beat = r_csum;
`endif
      default: w_beat = '0;
    endcase
  end

  assign out_data = w_beat;
  assign out_last = w_last;

endmodule

// File: tb/tb_pipe_out_serializer.sv
// tb/tb_pipe_out_serializer.sv - self-checking bench for pipe_out_serializer
module tb_pipe_out_serializer;

  localparam int NDATA = 4;
`ifdef PIPE_SER_CHECKSUM_EN
  localparam int FRAME = NDATA + 2;
`else
  localparam int FRAME = NDATA + 1;
`endif
  localparam logic [7:0] NB8 = 8'(FRAME - 1);

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         in_enq__ENA = 1'b0;
  logic [143:0] in_enq_v = '0;
  logic         in_enq__RDY;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_last;
  logic         out_ready = 1'b0;

  always #5 CLK = ~CLK;

  pipe_out_serializer dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .in_enq__ENA (in_enq__ENA),
    .in_enq_v    (in_enq_v),
    .in_enq__RDY (in_enq__RDY),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready)
  );

  int compared = 0;
  int mismatched = 0;
  int edge_cnt = 0;
  bit done = 1'b0;

  always @(posedge CLK) edge_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Model: buffered messages with the edge they were accepted, the index of
  // the beat being presented, and the edge the previous frame ended.
  typedef struct {
    logic [15:0]  tag;
    logic [127:0] data;
    int           enq;
  } mq_t;

  mq_t  mq[$];
  int   beat_idx = 0;
  int   prev_end = 0;
  logic m_rdy = 1'b0;
  logic rst_edge = 1'b0;
  logic stalled_prev = 1'b0;
  logic [31:0] prev_data = '0;
  logic prev_last = 1'b0;

  logic [31:0] lg_data[$];
  logic        lg_last[$];
  int          lg_edge[$];

  function automatic logic [31:0] exp_beat(input logic [15:0] tag, input logic [127:0] data, input int j);
    logic [31:0] x;
    x = {8'hA5, NB8, tag};
    if (j == 0) return x;
    if (j <= NDATA) return data[(j-1)*32 +: 32];
    for (int k = 0; k < NDATA; k++) x = x ^ data[k*32 +: 32];
    return x;
  endfunction

  always @(negedge CLK) begin : cmp
    logic ev;
    logic [31:0] eb;
    logic el;
    int start;
    ev = 1'b0;
    if (mq.size() > 0) begin
      start = (mq[0].enq + 1 > prev_end) ? mq[0].enq + 1 : prev_end;
      ev = (edge_cnt >= start);
    end
    if (edge_cnt >= 1) begin
      chk("in_enq__RDY", in_enq__RDY, m_rdy);
      chk("out_valid", out_valid, ev);
      if (rst_edge) begin
        chk("reset out_data", out_data, 32'h0);
        chk("reset out_last", out_last, 1'b0);
      end
      if (ev) begin
        eb = exp_beat(mq[0].tag, mq[0].data, beat_idx);
        el = (beat_idx == FRAME - 1);
        chk("out_data", out_data, eb);
        chk("out_last", out_last, el);
      end
      if (stalled_prev && out_valid) begin
        chk("stall hold data", out_data, prev_data);
        chk("stall hold last", out_last, prev_last);
      end
      stalled_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      if (out_valid && out_ready && nRST) begin
        lg_data.push_back(out_data);
        lg_last.push_back(out_last);
        lg_edge.push_back(edge_cnt + 1);
      end
    end
    if (!nRST) begin
      mq.delete();
      beat_idx = 0;
      prev_end = edge_cnt + 1;
      m_rdy = 1'b0;
      rst_edge = 1'b1;
      stalled_prev = 1'b0;
    end else begin
      rst_edge = 1'b0;
      if (ev && out_ready) begin
        if (beat_idx == FRAME - 1) begin
          void'(mq.pop_front());
          beat_idx = 0;
          prev_end = edge_cnt + 1;
        end else begin
          beat_idx++;
        end
      end
      if (in_enq__ENA && m_rdy) mq.push_back('{in_enq_v[143:128], in_enq_v[127:0], edge_cnt + 1});
      m_rdy = (mq.size() < 2);
    end
  end

  task automatic send(input logic [15:0] tag, input logic [127:0] data, output int acc);
    int n;
    n = 0;
    acc = -1;
    in_enq__ENA = 1'b1;
    in_enq_v = {tag, data};
    while (acc < 0 && n < 200) begin
      @(negedge CLK);
      if (in_enq__RDY) acc = edge_cnt + 1;
      @(posedge CLK);
      #1;
      n++;
    end
    in_enq__ENA = 1'b0;
    if (acc < 0) begin
      compared++;
      mismatched++;
      $display("FAIL send timeout: tag %0h not accepted", tag);
    end
  endtask

  task automatic wait_hs(input int n, input int budget);
    int k;
    k = 0;
    while (lg_data.size() < n && k < budget) begin
      @(posedge CLK);
      #1;
      k++;
    end
    chk("beats received", lg_data.size() >= n, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    lg_data.delete();
    lg_last.delete();
    lg_edge.delete();
  endtask

  function automatic int count_last();
    int c;
    c = 0;
    foreach (lg_last[i]) if (lg_last[i]) c++;
    return c;
  endfunction

  initial begin : stim
    int a0, a1, a2;
    int gaps;
    logic [31:0] t1_exp [0:5];
    logic [15:0] pat;
    logic [31:0] w;

`ifdef PIPE_SER_CHECKSUM_EN
    t1_exp = '{32'hA5050007, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'hE1414443};
`else
    t1_exp = '{32'hA5040007, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h0};
`endif

    out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    idle(1);

    // single message, literal beats and latency
    clear_log();
    send(16'h0007, 128'h44444444_33333333_22222222_11111111, a0);
    wait_hs(FRAME, 40);
    idle(2);
    chk("t1 beat count", lg_data.size(), FRAME);
    if (lg_data.size() >= FRAME) begin
      for (int i = 0; i < FRAME; i++) begin
        chk("t1 literal beat", lg_data[i], t1_exp[i]);
        chk("t1 literal last", lg_last[i], (i == FRAME - 1));
      end
      chk("t1 header latency", lg_edge[0], a0 + 2);
    end

    // three back-to-back messages
    clear_log();
    send(16'h0101, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000, a0);
    send(16'h0202, 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000, a1);
    send(16'h0303, 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000, a2);
    wait_hs(3 * FRAME, 100);
    idle(2);
    chk("t2 beat count", lg_data.size(), 3 * FRAME);
    gaps = 0;
    for (int i = 1; i < lg_edge.size(); i++) if (lg_edge[i] != lg_edge[i-1] + 1) gaps++;
    chk("t2 bubbles", gaps, 0);
    chk("t2 second accept", a1, a0 + 1);
    if (lg_edge.size() >= FRAME) chk("t2 third accept", a2, lg_edge[FRAME-1] + 1);
    chk("t2 last count", count_last(), 3);

    // stall pattern during a frame
    clear_log();
    pat = 16'b1011_0100_1011_0011;
    send(16'h0044, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, a0);
    for (int i = 0; i < 16; i++) begin
      out_ready = pat[i];
      @(posedge CLK);
      #1;
    end
    out_ready = 1'b1;
    wait_hs(FRAME, 40);
    idle(2);
    chk("t3 beat count", lg_data.size(), FRAME);
    if (lg_data.size() >= FRAME) begin
      chk("t3 header", lg_data[0], {8'hA5, NB8, 16'h0044});
      chk("t3 first data", lg_data[1], 32'h0A0A0A0A);
      chk("t3 fourth data", lg_data[4], 32'h0D0D0D0D);
    end
    chk("t3 last count", count_last(), 1);

    // reset after two beats of a frame
    clear_log();
    send(16'h0055, 128'h1, a0);
    wait_hs(2, 20);
    nRST = 1'b0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    idle(3);
    chk("t4 beats before reset", lg_data.size(), 2);
    chk("t4 no last on abandoned frame", count_last(), 0);
    clear_log();
    send(16'h00C3, 128'h5, a0);
    wait_hs(FRAME, 40);
    idle(2);
    if (lg_data.size() >= 1) begin
      w = lg_data[0];
      chk("t4 new header top", w[31:16], {8'hA5, NB8});
      chk("t4 new header tag", w[15:0], 16'h00C3);
    end

    // enqueue strobe while full is dropped
    clear_log();
    out_ready = 1'b0;
    send(16'h0A0A, 128'hA, a0);
    send(16'h0B0B, 128'hB, a1);
    in_enq__ENA = 1'b1;
    in_enq_v = {16'h0C0C, 128'hC};
    @(posedge CLK);
    #1 in_enq__ENA = 1'b0;
    out_ready = 1'b1;
    wait_hs(2 * FRAME, 60);
    idle(FRAME + 4);
    chk("t5 beat count", lg_data.size(), 2 * FRAME);
    chk("t5 last count", count_last(), 2);
    if (lg_data.size() >= 2 * FRAME) begin
      chk("t5 frame1 header", lg_data[0], {8'hA5, NB8, 16'h0A0A});
      chk("t5 frame2 header", lg_data[FRAME], {8'hA5, NB8, 16'h0B0B});
    end

`ifdef PIPE_SER_CHECKSUM_EN
    // zero message with trailer
    clear_log();
    send(16'h0000, 128'h0, a0);
    wait_hs(FRAME, 40);
    idle(2);
    if (lg_data.size() >= FRAME) begin
      chk("t6 header", lg_data[0], 32'hA5050000);
      for (int i = 1; i <= NDATA; i++) chk("t6 zero data", lg_data[i], 32'h0);
      chk("t6 trailer", lg_data[FRAME-1], 32'hA5050000);
      chk("t6 trailer last", lg_last[FRAME-1], 1'b1);
    end
`endif

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #400000;
    if (!done) begin
      $display("FAIL watchdog: bench did not complete, %0d compared / %0d mismatched", compared, mismatched);
      $fatal(1);
    end
  end

endmodule
